rtc_port_bank: RTL

Parametrised PicoBlaze I/O register bank between the soft processor and the RTC read/write controller. Holds a shadow copy of NUM_FIELDS time/timer fields written over the port bus. On command it commits them atomically to the RTC side and runs a request/acknowledge/done handshake with timeout. It also provides a registered read-back path, a one-hot field-select decode and a sticky status register.

---
 rtl/rtc_port_pkg.sv | 33 +++
 rtl/rtc_commit_fsm.sv | 98 +++++++++
 rtl/rtc_port_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rtc_port_pkg.sv
// ============================================================================
// Module : rtc_port_pkg
// Brief  : Shared types and constants for the RTC PicoBlaze port bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } commit_state_e;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_TMO      = 2;
    localparam int STAT_OVR      = 3;
    localparam int STAT_BCDERR   = 4;
    localparam int STAT_DONE_LVL = 5;

    localparam logic [7:0] DEF_SEL_ADDR    = 8'h01;
    localparam logic [7:0] DEF_WR_BASE     = 8'h02;
    localparam logic [7:0] DEF_COMMIT_ADDR = 8'h0B;
    localparam logic [7:0] DEF_STATUS_ADDR = 8'h0C;
    localparam logic [7:0] DEF_RD_BASE     = 8'h0D;

    localparam logic [7:0] COMMIT_CMD      = 8'h01;

endpackage

`default_nettype wire

// File: rtl/rtc_commit_fsm.sv
// ============================================================================
// Module : rtc_commit_fsm
// Brief  : Commit request/ack/done handshake with timeout and rtc_done edge
//          detection; emits single-cycle done/timeout/overrun events.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_commit_fsm
    import rtc_port_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic commit_cmd,
    input  logic commit_ack,
    input  logic rtc_done,
    output logic commit_req,
    output logic busy,
    output logic commit_accept,
    output logic done_evt,
    output logic tmo_evt,
    output logic ovr_evt
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    commit_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_lvl_q, done_lvl_d;

    logic w_done_rise;
    logic w_timeout;

    assign w_done_rise = rtc_done & ~done_lvl_q;
    assign w_timeout   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign done_lvl_d  = rtc_done;

    always_comb begin
        state_d       = state_q;
        commit_accept = 1'b0;
        done_evt      = 1'b0;
        tmo_evt       = 1'b0;
        ovr_evt       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_cmd) begin
                    state_d       = ST_REQ;
                    commit_accept = 1'b1;
                end
            end
            ST_REQ: begin
                ovr_evt = commit_cmd;
                // A done rise while still requesting doubles as the acknowledge.
                if (w_done_rise) begin
                    state_d  = ST_IDLE;
                    done_evt = 1'b1;
                end else if (commit_ack) begin
                    state_d = ST_WAIT;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    tmo_evt = 1'b1;
                end
            end
            ST_WAIT: begin
                ovr_evt = commit_cmd;
                if (w_done_rise) begin
                    state_d  = ST_IDLE;
                    done_evt = 1'b1;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    tmo_evt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            done_lvl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_lvl_q <= done_lvl_d;
        end
    end

    assign commit_req = (state_q == ST_REQ);
    assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/rtc_port_bank.sv
// ============================================================================
// Module : rtc_port_bank
// Brief  : PicoBlaze I/O register bank: shadow time fields, atomic commit to
//          the RTC writer, registered read-back, field select and status.
//          Optional RTC_BCD_CHECK_EN rejects shadow writes with non-BCD nibbles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_port_bank
    import rtc_port_pkg::*;
#(
    parameter int         NUM_FIELDS  = 9,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] SEL_ADDR    = DEF_SEL_ADDR,
    parameter logic [7:0] WR_BASE     = DEF_WR_BASE,
    parameter logic [7:0] COMMIT_ADDR = DEF_COMMIT_ADDR,
    parameter logic [7:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [7:0] RD_BASE     = DEF_RD_BASE,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_strobe,
    input  logic                         read_strobe,
    input  logic [7:0]                   port_id,
    input  logic [DATA_W-1:0]            out_port,
    output logic [DATA_W-1:0]            in_port,
    input  logic [NUM_FIELDS*DATA_W-1:0] rd_fields,
    output logic [NUM_FIELDS*DATA_W-1:0] field_q,
    output logic [NUM_FIELDS-1:0]        sel_onehot,
    output logic                         commit_req,
    input  logic                         commit_ack,
    input  logic                         rtc_done
);

    logic [NUM_FIELDS-1:0][DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_FIELDS*DATA_W-1:0]      field_d;
    logic [DATA_W-1:0]                 in_port_q, in_port_d;
    logic [NUM_FIELDS-1:0]             sel_onehot_q, sel_onehot_d;
    logic [DATA_W-1:0]                 sel_idx_q, sel_idx_d;
    logic                              sel_valid_q, sel_valid_d;
    logic                              done_q, done_d;
    logic                              tmo_q, tmo_d;
    logic                              ovr_q, ovr_d;
    logic                              bcderr_q, bcderr_d;

    logic [7:0]        w_wr_off;
    logic [7:0]        w_rd_off;
    logic              w_wr_hit;
    logic              w_sel_wr;
    logic              w_commit_cmd;
    logic              w_status_rd;
    logic              w_bcd_ok;
    logic              w_bcd_evt;
    logic [DATA_W-1:0] w_status;
    logic              w_busy;
    logic              w_commit_accept;
    logic              w_done_evt;
    logic              w_tmo_evt;
    logic              w_ovr_evt;

    // Offsets wrap for addresses below the base, so one unsigned compare covers the range.
    assign w_wr_off     = port_id - WR_BASE;
    assign w_rd_off     = port_id - RD_BASE;
    assign w_wr_hit     = write_strobe && (w_wr_off < 8'(NUM_FIELDS));
    assign w_sel_wr     = write_strobe && (port_id == SEL_ADDR);
    assign w_commit_cmd = write_strobe && (port_id == COMMIT_ADDR)
                          && (out_port == DATA_W'(COMMIT_CMD));
    assign w_status_rd  = read_strobe && (port_id == STATUS_ADDR);

`ifdef RTC_BCD_CHECK_EN
    always_comb begin
        w_bcd_ok = 1'b1;
        for (int n = 0; n < DATA_W / 4; n++) begin
            if (out_port[n*4 +: 4] > 4'd9) begin
                w_bcd_ok = 1'b0;
            end
        end
    end
`else
    assign w_bcd_ok = 1'b1;
`endif

    rtc_commit_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_commit_fsm (
        .clk           (clk),
        .reset         (reset),
        .commit_cmd    (w_commit_cmd),
        .commit_ack    (commit_ack),
        .rtc_done      (rtc_done),
        .commit_req    (commit_req),
        .busy          (w_busy),
        .commit_accept (w_commit_accept),
        .done_evt      (w_done_evt),
        .tmo_evt       (w_tmo_evt),
        .ovr_evt       (w_ovr_evt)
    );

    always_comb begin
        shadow_d  = shadow_q;
        w_bcd_evt = 1'b0;
        if (w_wr_hit) begin
            if (w_bcd_ok) begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (w_wr_off == 8'(i)) begin
                        shadow_d[i] = out_port;
                    end
                end
            end else begin
                w_bcd_evt = 1'b1;
            end
        end
        field_d = w_commit_accept ? shadow_q : field_q;
    end

    always_comb begin
        sel_onehot_d = sel_onehot_q;
        sel_idx_d    = sel_idx_q;
        sel_valid_d  = sel_valid_q;
        if (w_sel_wr) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                sel_onehot_d[i] = (out_port == DATA_W'(i));
            end
            sel_valid_d = |sel_onehot_d;
            sel_idx_d   = out_port;
        end
    end

    // Event set has priority over a same-edge status-read clear.
    always_comb begin
        done_d   = (done_q   & ~w_status_rd) | w_done_evt;
        tmo_d    = (tmo_q    & ~w_status_rd) | w_tmo_evt;
        ovr_d    = (ovr_q    & ~w_status_rd) | w_ovr_evt;
        bcderr_d = (bcderr_q & ~w_status_rd) | w_bcd_evt;
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_BUSY]     = w_busy;
        w_status[STAT_DONE]     = done_q;
        w_status[STAT_TMO]      = tmo_q;
        w_status[STAT_OVR]      = ovr_q;
        w_status[STAT_BCDERR]   = bcderr_q;
        w_status[STAT_DONE_LVL] = rtc_done;
    end

    always_comb begin
        in_port_d = '0;
        if (w_rd_off < 8'(NUM_FIELDS)) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (w_rd_off == 8'(i)) begin
                    in_port_d = rd_fields[i*DATA_W +: DATA_W];
                end
            end
        end else if (port_id == STATUS_ADDR) begin
            in_port_d = w_status;
        end else if (port_id == SEL_ADDR) begin
            in_port_d = sel_valid_q ? sel_idx_q : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q     <= '0;
            field_q      <= '0;
            in_port_q    <= '0;
            sel_onehot_q <= '0;
            sel_idx_q    <= '0;
            sel_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
            ovr_q        <= 1'b0;
            bcderr_q     <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            field_q      <= field_d;
            in_port_q    <= in_port_d;
            sel_onehot_q <= sel_onehot_d;
            sel_idx_q    <= sel_idx_d;
            sel_valid_q  <= sel_valid_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
            ovr_q        <= ovr_d;
            bcderr_q     <= bcderr_d;
        end
    end

    assign in_port    = in_port_q;
    assign sel_onehot = sel_onehot_q;

endmodule

`default_nettype wire
